dest_tag_pipeline: RTL and testbench



---
 rtl/pipe_tag_pkg.sv | 30 +++
 rtl/dest_tag_pipeline_tag_stage.sv | 21 ++
 rtl/dest_tag_pipeline.sv | 148 ++++++++++++++
 tb/tb_dest_tag_pipeline.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_tag_pkg.sv
// Shared types for the destination-tag pipeline: stage tag payload, operand
// encoding and the load-use FSM states.
package pipe_tag_pkg;

  localparam int unsigned REG_W  = 3;
  localparam int unsigned OPND_W = 4;

  // Operand code meaning "this instruction has no such operand".
  localparam logic [OPND_W-1:0] NO_REG = 4'b1000;

  typedef struct packed {
    logic [REG_W-1:0] rdest;
    logic             reg_write;
    logic             mem_read;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  typedef enum logic {
    RUN       = 1'b0,
    LU_BUBBLE = 1'b1
  } lu_state_t;

  // True when a decode operand names a real register equal to rdest.
  function automatic logic opnd_match(input logic [OPND_W-1:0] opnd,
                                      input logic [REG_W-1:0]  rdest);
    return !opnd[OPND_W-1] && (opnd[REG_W-1:0] == rdest);
  endfunction

endpackage

// File: rtl/dest_tag_pipeline_tag_stage.sv
// One pipeline register for a destination tag: en advances, clr loads a bubble.
module tag_stage
  import pipe_tag_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [TAG_W-1:0] d,
  output logic [TAG_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/dest_tag_pipeline.sv
// Destination-tag pipeline (ID/EX -> EX/MEM -> MEM/WB) with load-use bubble
// insertion. In-port capture is built only when DEST_TAG_IN_PORT_EN is defined.
module dest_tag_pipeline
  import pipe_tag_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        id_rdest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_in_port_select,
  input  logic [3:0]        id_rsrc_use,
  input  logic [3:0]        id_rdest_use,
  input  logic [DATA_W-1:0] in_port,
  input  logic              mem_stall,
  input  logic              flush,
  output logic [2:0]        ex_mem_rdest,
  output logic              ex_mem_reg_write,
  output logic [2:0]        mem_wb_rdest,
  output logic              mem_wb_reg_write,
  output logic              ex_inPortSelect,
  output logic [DATA_W-1:0] ex_inPortValue,
  output logic              mem_inPortSelect,
  output logic [DATA_W-1:0] mem_inPortValue,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  lu_stall_count
);

  lu_state_t        state;
  tag_t             id_tag;
  tag_t             id_ex;
  tag_t             ex_mem;
  tag_t             mem_wb;
  logic [TAG_W-1:0] id_ex_q;
  logic [TAG_W-1:0] ex_mem_q;
  logic [TAG_W-1:0] mem_wb_q;
  logic             adv;
  logic             bubble;
  logic             lu_hit;
  logic             unused_mem_wb_read;

  assign adv    = !mem_stall;
  assign id_tag = '{rdest: id_rdest, reg_write: id_reg_write, mem_read: id_mem_read};
  assign id_ex  = tag_t'(id_ex_q);
  assign ex_mem = tag_t'(ex_mem_q);
  assign mem_wb = tag_t'(mem_wb_q);

  // Load in ID/EX whose result a decode operand needs before it can be forwarded.
  assign lu_hit = id_ex.mem_read && id_ex.reg_write &&
                  (opnd_match(id_rsrc_use, id_ex.rdest) ||
                   opnd_match(id_rdest_use, id_ex.rdest));

  assign hazard_stall = (state == RUN) && lu_hit && !flush;
  assign bubble       = hazard_stall || flush;

  tag_stage u_id_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .clr   (bubble),
    .d     (TAG_W'(id_tag)),
    .q     (id_ex_q)
  );

  tag_stage u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .clr   (1'b0),
    .d     (id_ex_q),
    .q     (ex_mem_q)
  );

  tag_stage u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .clr   (1'b0),
    .d     (ex_mem_q),
    .q     (mem_wb_q)
  );

  assign ex_mem_rdest       = ex_mem.rdest;
  assign ex_mem_reg_write   = ex_mem.reg_write;
  assign mem_wb_rdest       = mem_wb.rdest;
  assign mem_wb_reg_write   = mem_wb.reg_write;
  // Load flag has no consumer past write-back.
  assign unused_mem_wb_read = mem_wb.mem_read;

  // Load-use FSM and saturating stall counter; both freeze under mem_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      lu_stall_count <= '0;
    end else if (adv) begin
      case (state)
        RUN:       if (hazard_stall) state <= LU_BUBBLE;
        LU_BUBBLE: state <= RUN;
        default:   state <= RUN;
      endcase
      if (hazard_stall && (lu_stall_count != '1)) begin
        lu_stall_count <= lu_stall_count + CNT_W'(1);
      end
    end
  end

`ifdef DEST_TAG_IN_PORT_EN
  logic              id_ex_in_sel;
  logic              ex_in_sel;
  logic              mem_in_sel;
  logic [DATA_W-1:0] ex_in_val;
  logic [DATA_W-1:0] mem_in_val;

  // In-port value is sampled as an IN instruction leaves ID/EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_in_sel <= 1'b0;
      ex_in_sel    <= 1'b0;
      ex_in_val    <= '0;
      mem_in_sel   <= 1'b0;
      mem_in_val   <= '0;
    end else if (adv) begin
      id_ex_in_sel <= bubble ? 1'b0 : id_in_port_select;
      ex_in_sel    <= id_ex_in_sel;
      ex_in_val    <= id_ex_in_sel ? in_port : '0;
      mem_in_sel   <= ex_in_sel;
      mem_in_val   <= ex_in_val;
    end
  end

  assign ex_inPortSelect  = ex_in_sel;
  assign ex_inPortValue   = ex_in_val;
  assign mem_inPortSelect = mem_in_sel;
  assign mem_inPortValue  = mem_in_val;
`else
  logic unused_in;

  assign unused_in        = ^{in_port, id_in_port_select};
  assign ex_inPortSelect  = 1'b0;
  assign ex_inPortValue   = '0;
  assign mem_inPortSelect = 1'b0;
  assign mem_inPortValue  = '0;
`endif

endmodule

// File: tb/tb_dest_tag_pipeline.sv
// Self-checking bench for dest_tag_pipeline: directed scenarios followed by
// random traffic, all compared against a stage-array reference model.
module tb_dest_tag_pipeline;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;
  localparam logic [3:0]  NOP = 4'b1000;
`ifdef DEST_TAG_IN_PORT_EN
  localparam bit IN_EN = 1'b1;
`else
  localparam bit IN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    id_rdest = '0;
  logic          id_reg_write = 1'b0;
  logic          id_mem_read = 1'b0;
  logic          id_in_port_select = 1'b0;
  logic [3:0]    id_rsrc_use = NOP;
  logic [3:0]    id_rdest_use = NOP;
  logic [DW-1:0] in_port = '0;
  logic          mem_stall = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    ex_mem_rdest;
  logic          ex_mem_reg_write;
  logic [2:0]    mem_wb_rdest;
  logic          mem_wb_reg_write;
  logic          ex_inPortSelect;
  logic [DW-1:0] ex_inPortValue;
  logic          mem_inPortSelect;
  logic [DW-1:0] mem_inPortValue;
  logic          hazard_stall;
  logic [CW-1:0] lu_stall_count;

  dest_tag_pipeline #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rdest          (id_rdest),
    .id_reg_write      (id_reg_write),
    .id_mem_read       (id_mem_read),
    .id_in_port_select (id_in_port_select),
    .id_rsrc_use       (id_rsrc_use),
    .id_rdest_use      (id_rdest_use),
    .in_port           (in_port),
    .mem_stall         (mem_stall),
    .flush             (flush),
    .ex_mem_rdest      (ex_mem_rdest),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .mem_wb_rdest      (mem_wb_rdest),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .ex_inPortSelect   (ex_inPortSelect),
    .ex_inPortValue    (ex_inPortValue),
    .mem_inPortSelect  (mem_inPortSelect),
    .mem_inPortValue   (mem_inPortValue),
    .hazard_stall      (hazard_stall),
    .lu_stall_count    (lu_stall_count)
  );

  always #5 clk = ~clk;

  // Reference pipeline: slot 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
  typedef struct {
    logic [2:0]    rd;
    logic          rw;
    logic          mr;
    logic          isel;
    logic [DW-1:0] ival;
  } slot_t;

  slot_t       pipe [3];
  int unsigned m_cnt;
  int          total = 0;
  int          bad = 0;
  logic        h_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{rd: '0, rw: 1'b0, mr: 1'b0, isel: 1'b0, ival: '0};
    m_cnt = 0;
  endtask

  function automatic bit needs(input logic [3:0] op, input logic [2:0] rd);
    return (op < 4'd8) && (op[2:0] == rd);
  endfunction

  function automatic bit model_haz();
    return pipe[0].mr && pipe[0].rw && !flush &&
           (needs(id_rsrc_use, pipe[0].rd) || needs(id_rdest_use, pipe[0].rd));
  endfunction

  task automatic model_step(input bit haz);
    if (mem_stall) return;
    if (haz && m_cnt < (1 << CW) - 1) m_cnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[1].ival = pipe[0].isel ? in_port : '0;
    if (haz || flush) pipe[0] = '{rd: '0, rw: 1'b0, mr: 1'b0, isel: 1'b0, ival: '0};
    else pipe[0] = '{rd: id_rdest, rw: id_reg_write, mr: id_mem_read,
                     isel: id_in_port_select, ival: '0};
  endtask

  task automatic check_outputs();
    logic          exs, mems;
    logic [DW-1:0] exv, memv;
    exs  = IN_EN ? pipe[1].isel : 1'b0;
    exv  = IN_EN ? pipe[1].ival : '0;
    mems = IN_EN ? pipe[2].isel : 1'b0;
    memv = IN_EN ? pipe[2].ival : '0;
    check_eq("ex_mem_rdest",     32'(ex_mem_rdest),     32'(pipe[1].rd));
    check_eq("ex_mem_reg_write", 32'(ex_mem_reg_write), 32'(pipe[1].rw));
    check_eq("mem_wb_rdest",     32'(mem_wb_rdest),     32'(pipe[2].rd));
    check_eq("mem_wb_reg_write", 32'(mem_wb_reg_write), 32'(pipe[2].rw));
    check_eq("ex_in_sel",        32'(ex_inPortSelect),  32'(exs));
    check_eq("ex_in_val",        32'(ex_inPortValue),   32'(exv));
    check_eq("mem_in_sel",       32'(mem_inPortSelect), 32'(mems));
    check_eq("mem_in_val",       32'(mem_inPortValue),  32'(memv));
    check_eq("lu_stall_count",   32'(lu_stall_count),   32'(m_cnt));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    bit h;
    #1;
    h = model_haz();
    h_seen = hazard_stall;
    check_eq("hazard_stall", 32'(hazard_stall), 32'(h));
    @(posedge clk);
    model_step(h);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic dec(input logic [2:0] rd, input logic rw, input logic mr, input logic isel,
                     input logic [3:0] rs, input logic [3:0] ru);
    id_rdest = rd;
    id_reg_write = rw;
    id_mem_read = mr;
    id_in_port_select = isel;
    id_rsrc_use = rs;
    id_rdest_use = ru;
  endtask

  task automatic nop();
    dec(3'd0, 1'b0, 1'b0, 1'b0, NOP, NOP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    check_eq("rst_hazard", 32'(hazard_stall), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Tag latency: r3 write seen on EX/MEM after 2 edges, MEM/WB after 3.
    dec(3'd3, 1'b1, 1'b0, 1'b0, NOP, NOP);
    tick();
    nop();
    tick();
    check_eq("lat_ex_rdest", 32'(ex_mem_rdest), 32'd3);
    check_eq("lat_ex_rw", 32'(ex_mem_reg_write), 32'd1);
    tick();
    check_eq("lat_wb_rdest", 32'(mem_wb_rdest), 32'd3);

    // Load r2 then use r2: one-cycle stall, then bubble follows the load.
    dec(3'd2, 1'b1, 1'b1, 1'b0, NOP, NOP);
    tick();
    dec(3'd5, 1'b1, 1'b0, 1'b0, 4'b0010, NOP);
    tick();
    check_eq("lu_stall_hi", 32'(h_seen), 32'd1);
    check_eq("lu_cnt1", 32'(lu_stall_count), 32'd1);
    check_eq("lu_ex_load", 32'(ex_mem_rdest), 32'd2);
    tick();
    check_eq("lu_stall_once", 32'(h_seen), 32'd0);
    check_eq("lu_ex_bubble", 32'(ex_mem_reg_write), 32'd0);
    nop();
    tick();

    // No-operand encoding never matches.
    dec(3'd2, 1'b1, 1'b1, 1'b0, NOP, NOP);
    tick();
    dec(3'd5, 1'b1, 1'b0, 1'b0, 4'b1010, NOP);
    tick();
    check_eq("noop_no_stall", 32'(h_seen), 32'd0);
    nop();
    tick();

    // IN r1 with a held in-port value.
    in_port = 16'hBEEF;
    dec(3'd1, 1'b1, 1'b0, 1'b1, NOP, NOP);
    tick();
    nop();
    tick();
    check_eq("in_ex_sel", 32'(ex_inPortSelect), 32'(IN_EN));
    check_eq("in_ex_val", 32'(ex_inPortValue), IN_EN ? 32'h0000BEEF : 32'd0);
    tick();
    check_eq("in_mem_sel", 32'(mem_inPortSelect), 32'(IN_EN));
    check_eq("in_mem_val", 32'(mem_inPortValue), IN_EN ? 32'h0000BEEF : 32'd0);

    // Load-use held under mem_stall: stall for 3 + 1 cycles, count once.
    dec(3'd4, 1'b1, 1'b1, 1'b0, NOP, NOP);
    tick();
    dec(3'd0, 1'b0, 1'b0, 1'b0, NOP, 4'b0100);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ms_stall_hi", 32'(h_seen), 32'd1);
    end
    check_eq("ms_cnt_frozen", 32'(lu_stall_count), 32'd1);
    mem_stall = 1'b0;
    tick();
    check_eq("ms_stall_last", 32'(h_seen), 32'd1);
    check_eq("ms_cnt_inc", 32'(lu_stall_count), 32'd2);
    tick();
    check_eq("ms_stall_done", 32'(h_seen), 32'd0);
    nop();
    tick();

    // Flush wins over a load-use match.
    dec(3'd2, 1'b1, 1'b1, 1'b0, NOP, NOP);
    tick();
    dec(3'd0, 1'b0, 1'b0, 1'b0, 4'b0010, NOP);
    flush = 1'b1;
    tick();
    check_eq("fl_no_stall", 32'(h_seen), 32'd0);
    check_eq("fl_cnt_same", 32'(lu_stall_count), 32'd2);
    flush = 1'b0;
    nop();
    tick();
    check_eq("fl_bubble", 32'(ex_mem_reg_write), 32'd0);

    // Reset while in the bubble cycle.
    dec(3'd6, 1'b1, 1'b1, 1'b0, NOP, NOP);
    tick();
    dec(3'd0, 1'b0, 1'b0, 1'b0, 4'b0110, NOP);
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_mid_haz", 32'(hazard_stall), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    dec(3'd6, 1'b1, 1'b1, 1'b0, NOP, NOP);
    tick();
    dec(3'd0, 1'b0, 1'b0, 1'b0, 4'b0110, NOP);
    tick();
    check_eq("rst_run_again", 32'(h_seen), 32'd1);
    check_eq("rst_cnt_restart", 32'(lu_stall_count), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] rd;
      rd = 3'($urandom_range(0, 7));
      dec(rd, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          ($urandom_range(0, 1) != 0) ? {1'b0, 3'($urandom_range(0, 7))} : 4'($urandom_range(0, 15)),
          ($urandom_range(0, 2) == 0) ? {1'b0, 3'($urandom_range(0, 7))} : NOP);
      in_port = DW'($urandom);
      mem_stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end

    // Counter saturation at all-ones.
    mem_stall = 1'b0;
    flush = 1'b0;
    for (int n = 0; n < 9; n++) begin
      dec(3'd7, 1'b1, 1'b1, 1'b0, NOP, NOP);
      tick();
      dec(3'd0, 1'b0, 1'b0, 1'b0, 4'b0111, NOP);
      tick();
      nop();
      tick();
    end
    check_eq("cnt_saturated", 32'(lu_stall_count), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
